// File: rtl/pwm_capture.sv
// PWM period / high-time meter: results are in clk_i cycles and are published at each rising edge of pwm_in_i.
// A line that shows no rising edge for TIMEOUT_CYC cycles is reported through timeout_o.
module pwm_capture #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pwm_in_i,
  input  logic             clr_valid_i,
  output logic [WIDTH-1:0] period_out_o,
  output logic [WIDTH-1:0] high_out_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             timeout_o,
  output logic             level_o
);

  // state      | meaning
  // WAIT_FIRST | after reset: waiting for the first rising edge, nothing to publish yet
  // MEASURE    | counting; every rising edge publishes the period that just ended
  // STALL      | no rising edge for TIMEOUT_CYC cycles; results forced to 0
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALL      = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TO_CNT  = WIDTH'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic             to_hit;
  logic             publish;

  assign rise   = s2_q & ~s3_q;
  assign to_hit = (per_cnt_q == TO_CNT);

  // Both counters restart at 1 on the edge cycle itself, so the synchroniser delay cancels out.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
    end else begin
      if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_ONE;
      if (s2_q && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    timeout_d = timeout_q;
    publish   = 1'b0;
    case (state_q)
      WAIT_FIRST: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (to_hit) begin
          state_d   = STALL;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          publish  = 1'b1;
          period_d = per_cnt_q;
          high_d   = hi_cnt_q;
        end else if (to_hit) begin
          state_d   = STALL;
          timeout_d = 1'b1;
          period_d  = '0;
          high_d    = '0;
        end
      end
      STALL: begin
        // The partial period before this edge is meaningless and is dropped.
        if (rise) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  // A publish wins over a simultaneous clear; it never sets overrun in that cycle.
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (publish) begin
      valid_d = 1'b1;
      if (valid_q && !clr_valid_i) overrun_d = 1'b1;
    end else if (clr_valid_i) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= WAIT_FIRST;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= pwm_in_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out_o = period_q;
  assign high_out_o   = high_q;
  assign valid_o      = valid_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;
  assign level_o      = s2_q;

endmodule
